// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N buffered demultiplexer: select width,
// per-channel buffer state encoding and drop counter width.
package demux_pkg;

    localparam int DROP_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    // A two-channel demux still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry output buffer for a single demux channel; accepts a new word in
// the same cycle its current word is handed off, giving one word per cycle.
module demux_chan_buf
    import demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HOLD_LAST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             can_accept
);

    chan_state_t      state_q;
    chan_state_t      state_d;
    logic [WIDTH-1:0] buf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (wr_en) state_d = ST_FULL;
            ST_FULL:  if (!wr_en && out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Without HOLD_LAST the word is cleared on handoff so out_data stays a plain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (wr_en)
                buf_q <= wr_data;
            else if ((HOLD_LAST == 0) && (state_q == ST_FULL) && out_ready)
                buf_q <= '0;
        end
    end

    assign out_valid  = (state_q == ST_FULL);
    assign out_data   = buf_q;
    assign can_accept = (state_q == ST_EMPTY) || out_ready;

endmodule

// File: rtl/demux_1ton_buf.sv
// Registered 1-to-N demultiplexer with valid/ready handshake; each channel
// stalls independently and words addressed to a missing channel are dropped.
module demux_1ton_buf
    import demux_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int NCH       = 2,
    parameter  int HOLD_LAST = 1,
    localparam int SEL_W     = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic                 sel_err,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int NPAD = 1 << SEL_W;

    logic [NCH-1:0]    can_accept;
    logic [NCH-1:0]    wr_en;
    logic [NPAD-1:0]   can_pad;
    logic [NPAD-1:0]   bad_pad;
    logic              sel_bad;
    logic              in_xfer;
    logic              sel_err_p1;
    logic [DROP_W-1:0] drop_cnt_p1;

    // Unused select codes always accept, so a bad word never stalls the bus.
    always_comb begin
        can_pad          = '1;
        can_pad[NCH-1:0] = can_accept;
        bad_pad          = '1;
        bad_pad[NCH-1:0] = '0;
    end

    assign sel_bad  = bad_pad[in_sel];
    assign in_ready = can_pad[in_sel];
    assign in_xfer  = in_valid && in_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign wr_en[i] = in_xfer && !sel_bad && (in_sel == SEL_W'(i));

        demux_chan_buf #(
            .WIDTH     (WIDTH),
            .HOLD_LAST (HOLD_LAST)
        ) u_buf (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_en[i]),
            .wr_data    (in_data),
            .out_valid  (out_valid[i]),
            .out_ready  (out_ready[i]),
            .out_data   (out_data[i*WIDTH +: WIDTH]),
            .can_accept (can_accept[i])
        );
    end

    // Stage p1: drop reporting, registered one cycle after the dropped transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_p1  <= 1'b0;
            drop_cnt_p1 <= '0;
        end else begin
            sel_err_p1 <= in_xfer && sel_bad;
            if (in_xfer && sel_bad && (drop_cnt_p1 != {DROP_W{1'b1}}))
                drop_cnt_p1 <= drop_cnt_p1 + DROP_W'(1);
        end
    end

    assign sel_err  = sel_err_p1;
    assign drop_cnt = drop_cnt_p1;

endmodule

// File: tb/tb_demux_1ton_buf.sv
// Bench for demux_1ton_buf: a 3-channel HOLD_LAST=1 instance and a 4-channel
// HOLD_LAST=0 instance, directed scenarios plus a randomized model comparison.
module tb_demux_1ton_buf;

    logic clk;
    logic reset;

    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [23:0] a_out_data;
    logic [2:0]  a_out_valid;
    logic [2:0]  a_out_ready;
    logic        a_sel_err;
    logic [7:0]  a_drop_cnt;

    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_out_data;
    logic [3:0]  b_out_valid;
    logic [3:0]  b_out_ready;
    logic        b_sel_err;
    logic [7:0]  b_drop_cnt;

    int tests = 0;
    int fails = 0;

    demux_1ton_buf #(.WIDTH(8), .NCH(3), .HOLD_LAST(1)) dut_a (
        .clk(clk), .reset(reset), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .sel_err(a_sel_err),
        .drop_cnt(a_drop_cnt)
    );

    demux_1ton_buf #(.WIDTH(8), .NCH(4), .HOLD_LAST(0)) dut_b (
        .clk(clk), .reset(reset), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err),
        .drop_cnt(b_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'hC3; a_out_ready = 3'b000;
        b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 8'h3C; b_out_ready = 4'b0000;
        tick();
        tick();
        tests++; if (a_out_valid !== 3'b000) begin fails++; $display("FAIL reset_a_valid got=%b exp=000", a_out_valid); end
        tests++; if (a_out_data !== 24'h0) begin fails++; $display("FAIL reset_a_data got=%h exp=000000", a_out_data); end
        tests++; if (a_drop_cnt !== 8'd0 || a_sel_err !== 1'b0) begin fails++; $display("FAIL reset_a_drop got=%0d/%b exp=0/0", a_drop_cnt, a_sel_err); end
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_a_ready got=%b exp=1", a_in_ready); end
        tests++; if (b_out_valid !== 4'b0000 || b_out_data !== 32'h0) begin fails++; $display("FAIL reset_b got=%b/%h exp=0000/00000000", b_out_valid, b_out_data); end
        tests++; if (b_drop_cnt !== 8'd0 || b_in_ready !== 1'b1) begin fails++; $display("FAIL reset_b_drop got=%0d/%b exp=0/1", b_drop_cnt, b_in_ready); end
        reset = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        a_out_ready = 3'b111;
        b_out_ready = 4'b1111;
        tick();
    endtask

    task automatic test_routing();
        b_out_ready = 4'b1111;
        b_in_data = 8'hA5; b_in_sel = 2'd2; b_in_valid = 1'b1;
        #1;
        tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL route_ready got=%b exp=1", b_in_ready); end
        tick();
        b_in_valid = 1'b0;
        tests++; if (b_out_valid !== 4'b0100) begin fails++; $display("FAIL route_valid got=%b exp=0100", b_out_valid); end
        tests++; if (b_out_data !== 32'h00A50000) begin fails++; $display("FAIL route_data got=%h exp=00a50000", b_out_data); end
        tick();
        tests++; if (b_out_valid !== 4'b0000) begin fails++; $display("FAIL route_drain got=%b exp=0000", b_out_valid); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 3'b000;
        a_in_data = 8'h11; a_in_sel = 2'd0; a_in_valid = 1'b1;
        #1;
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_first_ready got=%b exp=1", a_in_ready); end
        tick();
        tests++; if (a_out_valid[0] !== 1'b1 || a_out_data[7:0] !== 8'h11) begin fails++; $display("FAIL bp_first_word got=%b/%h exp=1/11", a_out_valid[0], a_out_data[7:0]); end
        a_in_data = 8'h22; a_in_sel = 2'd0;
        #1;
        tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready got=%b exp=0", a_in_ready); end
        tick();
        tests++; if (a_out_data[7:0] !== 8'h11 || a_out_valid !== 3'b001) begin fails++; $display("FAIL bp_hold got=%b/%h exp=001/11", a_out_valid, a_out_data[7:0]); end
        a_in_data = 8'h33; a_in_sel = 2'd1;
        #1;
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_other_ready got=%b exp=1", a_in_ready); end
        tick();
        tests++; if (a_out_valid !== 3'b011 || a_out_data[15:0] !== 16'h3311) begin fails++; $display("FAIL bp_other_word got=%b/%h exp=011/3311", a_out_valid, a_out_data[15:0]); end
        a_in_data = 8'h22; a_in_sel = 2'd0; a_out_ready = 3'b001;
        #1;
        tests++; if (a_in_ready !== 1'b1 || a_out_data[7:0] !== 8'h11) begin fails++; $display("FAIL bp_release got=%b/%h exp=1/11", a_in_ready, a_out_data[7:0]); end
        tick();
        a_in_valid = 1'b0;
        tests++; if (a_out_valid !== 3'b011 || a_out_data[7:0] !== 8'h22) begin fails++; $display("FAIL bp_second_word got=%b/%h exp=011/22", a_out_valid, a_out_data[7:0]); end
        tick();
        tests++; if (a_out_valid !== 3'b010 || a_out_data[15:0] !== 16'h3322) begin fails++; $display("FAIL bp_drained got=%b/%h exp=010/3322", a_out_valid, a_out_data[15:0]); end
        a_out_ready = 3'b111;
        tick();
        tests++; if (a_out_valid !== 3'b000) begin fails++; $display("FAIL bp_empty got=%b exp=000", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        int bad = 0;
        a_out_ready = 3'b010;
        for (int k = 0; k < 8; k++) begin
            w = 8'($urandom);
            a_in_data = w; a_in_sel = 2'd1; a_in_valid = 1'b1;
            #1;
            if (a_in_ready !== 1'b1) bad++;
            tick();
            tests++; if (a_out_valid[1] !== 1'b1 || a_out_data[15:8] !== w) begin fails++; $display("FAIL stream_word%0d got=%b/%h exp=1/%h", k, a_out_valid[1], a_out_data[15:8], w); end
        end
        a_in_valid = 1'b0;
        tests++; if (bad !== 0) begin fails++; $display("FAIL stream_ready stalls got=%0d exp=0", bad); end
        tick();
        tests++; if (a_out_valid !== 3'b000) begin fails++; $display("FAIL stream_drain got=%b exp=000", a_out_valid); end
        a_out_ready = 3'b111;
    endtask

    task automatic test_bad_sel();
        a_out_ready = 3'b000;
        a_in_sel = 2'd3; a_in_data = 8'hEE; a_in_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            #1;
            tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bad%0d_ready got=%b exp=1", k, a_in_ready); end
            tick();
            tests++; if (a_sel_err !== 1'b1 || a_drop_cnt !== 8'(k) || a_out_valid !== 3'b000) begin fails++; $display("FAIL bad%0d_flag got=%b/%0d/%b exp=1/%0d/000", k, a_sel_err, a_drop_cnt, a_out_valid, k); end
        end
        a_in_valid = 1'b0;
        tick();
        tests++; if (a_sel_err !== 1'b0 || a_drop_cnt !== 8'd2) begin fails++; $display("FAIL bad_idle got=%b/%0d exp=0/2", a_sel_err, a_drop_cnt); end
        a_in_valid = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        tests++; if (a_drop_cnt !== 8'd255 || a_sel_err !== 1'b1) begin fails++; $display("FAIL bad_saturate got=%0d/%b exp=255/1", a_drop_cnt, a_sel_err); end
        a_in_valid = 1'b0;
        a_out_ready = 3'b111;
        tick();
    endtask

    task automatic test_hold_last();
        a_out_ready = 3'b111; b_out_ready = 4'b1111;
        a_in_data = 8'h5A; a_in_sel = 2'd0; a_in_valid = 1'b1;
        b_in_data = 8'h5A; b_in_sel = 2'd0; b_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        tests++; if (a_out_data[7:0] !== 8'h5A || b_out_data[7:0] !== 8'h5A) begin fails++; $display("FAIL hold_deliver got=%h/%h exp=5a/5a", a_out_data[7:0], b_out_data[7:0]); end
        tick();
        tick();
        tests++; if (a_out_data[7:0] !== 8'h5A || a_out_valid[0] !== 1'b0) begin fails++; $display("FAIL hold_last1 got=%h/%b exp=5a/0", a_out_data[7:0], a_out_valid[0]); end
        tests++; if (b_out_data[7:0] !== 8'h00 || b_out_valid[0] !== 1'b0) begin fails++; $display("FAIL hold_last0 got=%h/%b exp=00/0", b_out_data[7:0], b_out_valid[0]); end
        a_out_ready = 3'b000;
        a_in_data = 8'h77; a_in_sel = 2'd0; a_in_valid = 1'b1;
        tick();
        tests++; if (a_out_valid[0] !== 1'b1) begin fails++; $display("FAIL rst_full_pre got=%b exp=1", a_out_valid[0]); end
        reset = 1'b1; a_out_ready = 3'b111; a_in_data = 8'h99;
        tick();
        tests++; if (a_out_valid !== 3'b000 || a_out_data !== 24'h0 || a_drop_cnt !== 8'd0) begin fails++; $display("FAIL rst_full got=%b/%h/%0d exp=000/000000/0", a_out_valid, a_out_data, a_drop_cnt); end
        reset = 1'b0; a_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit         full [2][4];
        logic [7:0] mdat [2][4];
        int         drop [2];
        bit         err  [2];
        int         nch  [2];
        bit         hold [2];
        bit         iv   [2];
        logic [1:0] isel [2];
        logic [7:0] idat [2];
        logic [3:0] orv  [2];
        bit         rdy  [2];
        bit         obs_rdy;
        logic [3:0] obs_v, exp_v;
        logic [31:0] obs_d, exp_d;
        logic [7:0] obs_cnt;
        logic       obs_err;
        nch[0] = 3; nch[1] = 4; hold[0] = 1'b1; hold[1] = 1'b0;
        reset = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drop[d] = 0; err[d] = 1'b0;
            for (int c = 0; c < 4; c++) begin full[d][c] = 1'b0; mdat[d][c] = 8'h00; end
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d] = ($urandom_range(0, 3) != 0);
                isel[d] = 2'($urandom_range(0, 3));
                idat[d] = 8'($urandom);
                orv[d] = 4'($urandom);
            end
            a_in_valid = iv[0]; a_in_sel = isel[0]; a_in_data = idat[0]; a_out_ready = orv[0][2:0];
            b_in_valid = iv[1]; b_in_sel = isel[1]; b_in_data = idat[1]; b_out_ready = orv[1];
            #1;
            for (int d = 0; d < 2; d++) begin
                obs_rdy = (d == 0) ? a_in_ready : b_in_ready;
                rdy[d] = (int'(isel[d]) >= nch[d]) || !full[d][isel[d]] || orv[d][isel[d]];
                tests++; if (obs_rdy !== rdy[d]) begin fails++; $display("FAIL rand%0d_ready cyc=%0d got=%b exp=%b", d, cyc, obs_rdy, rdy[d]); end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                int wch;
                wch = -1;
                err[d] = 1'b0;
                if (iv[d] && rdy[d]) begin
                    if (int'(isel[d]) >= nch[d]) begin
                        err[d] = 1'b1;
                        if (drop[d] < 255) drop[d]++;
                    end else begin
                        wch = int'(isel[d]);
                    end
                end
                for (int c = 0; c < nch[d]; c++) begin
                    if (c == wch) begin
                        full[d][c] = 1'b1; mdat[d][c] = idat[d];
                    end else if (full[d][c] && orv[d][c]) begin
                        full[d][c] = 1'b0;
                        if (!hold[d]) mdat[d][c] = 8'h00;
                    end
                end
                exp_v = '0; exp_d = '0;
                for (int c = 0; c < nch[d]; c++) begin
                    exp_v[c] = full[d][c];
                    exp_d[c*8 +: 8] = mdat[d][c];
                end
                obs_v   = (d == 0) ? {1'b0, a_out_valid} : b_out_valid;
                obs_d   = (d == 0) ? {8'h00, a_out_data} : b_out_data;
                obs_cnt = (d == 0) ? a_drop_cnt : b_drop_cnt;
                obs_err = (d == 0) ? a_sel_err : b_sel_err;
                tests++; if (obs_v !== exp_v || obs_d !== exp_d) begin fails++; $display("FAIL rand%0d_out cyc=%0d got=%b/%h exp=%b/%h", d, cyc, obs_v, obs_d, exp_v, exp_d); end
                tests++; if (obs_err !== err[d] || obs_cnt !== 8'(drop[d])) begin fails++; $display("FAIL rand%0d_drop cyc=%0d got=%b/%0d exp=%b/%0d", d, cyc, obs_err, obs_cnt, err[d], drop[d]); end
            end
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = '0;
        b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_bad_sel();
        test_hold_last();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
